// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - two-approach intersection phase sequencer with ped and emergency handling
//
// Sequences approaches A and B through green, yellow and all-red phases.
// All phase timing advances on the one-cycle 'tick' enable.
// Emergency pre-emption is evaluated on every clk.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   tick                 timing enable, one clk wide
//   ped_req_a/b          pedestrian button pulses (latched until served)
//   car_b                vehicle present on B (level)
//   emg_a/b              emergency vehicle present on A/B (level); A has priority
//   light_a/b            lamp code: 00 RED, 01 YEL, 10 GRN
//   walk_a/b             walk lamp, high through a served green
//   remain               ticks left in the current phase
//   phase                current state code
module traffic_phase_scheduler #(
    parameter int T_GRN    = 5,
    parameter int T_YEL    = 2,
    parameter int T_ALLRED = 1,
    parameter int T_WALK   = 3,
    parameter int CW       = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          ped_req_a,
    input  logic          ped_req_b,
    input  logic          car_b,
    input  logic          emg_a,
    input  logic          emg_b,
    output logic [1:0]    light_a,
    output logic [1:0]    light_b,
    output logic          walk_a,
    output logic          walk_b,
    output logic [CW-1:0] remain,
    output logic [2:0]    phase
);

    typedef enum logic [2:0] {
        A_GRN = 3'd0,
        A_YEL = 3'd1,
        AR_AB = 3'd2,
        B_GRN = 3'd3,
        B_YEL = 3'd4,
        AR_BA = 3'd5
    } state_t;

    localparam logic [CW-1:0] R_GRN      = CW'(T_GRN);
    localparam logic [CW-1:0] R_GRN_WALK = CW'(T_GRN + T_WALK);
    localparam logic [CW-1:0] R_YEL      = CW'(T_YEL);
    localparam logic [CW-1:0] R_AR       = CW'(T_ALLRED);
    localparam logic [CW-1:0] R_ONE      = CW'(1);

    localparam logic [1:0] L_RED = 2'b00;
    localparam logic [1:0] L_YEL = 2'b01;
    localparam logic [1:0] L_GRN = 2'b10;

    state_t        state, state_n;
    logic [CW-1:0] remain_n;
    logic          served_a, served_a_n;
    logic          served_b, served_b_n;
    logic          pend_a, pend_a_n;
    logic          pend_b, pend_b_n;

    // A request in the same cycle as the green entry is treated as already
    // latched, so it is served by that green.
    logic pend_a_set, pend_b_set;
    logic last_tick;

    assign pend_a_set = pend_a | ped_req_a;
    assign pend_b_set = pend_b | ped_req_b;
    assign last_tick  = tick && (remain <= R_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= A_GRN;
            remain   <= R_GRN;
            served_a <= 1'b0;
            served_b <= 1'b0;
            pend_a   <= 1'b0;
            pend_b   <= 1'b0;
        end else begin
            state    <= state_n;
            remain   <= remain_n;
            served_a <= served_a_n;
            served_b <= served_b_n;
            pend_a   <= pend_a_n;
            pend_b   <= pend_b_n;
        end
    end

    always_comb begin
        state_n    = state;
        remain_n   = remain;
        served_a_n = served_a;
        served_b_n = served_b;
        pend_a_n   = pend_a_set;
        pend_b_n   = pend_b_set;

        unique case (state)
            A_GRN: begin
                if (emg_a) begin
                    // Own-side emergency: hold green, count frozen.
                end else if (emg_b) begin
                    state_n    = A_YEL;
                    remain_n   = R_YEL;
                    served_a_n = 1'b0;
                end else if (tick) begin
                    if (!last_tick) begin
                        remain_n = remain - R_ONE;
                    end else if (car_b || pend_b_set) begin
                        state_n    = A_YEL;
                        remain_n   = R_YEL;
                        served_a_n = 1'b0;
                    end else begin
                        // No demand on B: rest on A with a fresh base green.
                        remain_n   = R_GRN;
                        served_a_n = 1'b0;
                    end
                end
            end
            A_YEL: begin
                if (tick) begin
                    if (!last_tick) begin
                        remain_n = remain - R_ONE;
                    end else begin
                        state_n  = AR_AB;
                        remain_n = R_AR;
                    end
                end
            end
            AR_AB: begin
                if (tick) begin
                    if (!last_tick) begin
                        remain_n = remain - R_ONE;
                    end else begin
                        state_n    = B_GRN;
                        served_b_n = pend_b_set;
                        remain_n   = pend_b_set ? R_GRN_WALK : R_GRN;
                        pend_b_n   = 1'b0;
                    end
                end
            end
            B_GRN: begin
                if (emg_a) begin
                    state_n    = B_YEL;
                    remain_n   = R_YEL;
                    served_b_n = 1'b0;
                end else if (emg_b) begin
                    // Own-side emergency: hold green, count frozen.
                end else if (tick) begin
                    if (!last_tick) begin
                        remain_n = remain - R_ONE;
                    end else begin
                        state_n    = B_YEL;
                        remain_n   = R_YEL;
                        served_b_n = 1'b0;
                    end
                end
            end
            B_YEL: begin
                if (tick) begin
                    if (!last_tick) begin
                        remain_n = remain - R_ONE;
                    end else begin
                        state_n  = AR_BA;
                        remain_n = R_AR;
                    end
                end
            end
            AR_BA: begin
                if (tick) begin
                    if (!last_tick) begin
                        remain_n = remain - R_ONE;
                    end else begin
                        state_n    = A_GRN;
                        served_a_n = pend_a_set;
                        remain_n   = pend_a_set ? R_GRN_WALK : R_GRN;
                        pend_a_n   = 1'b0;
                    end
                end
            end
            default: begin
                state_n    = A_GRN;
                remain_n   = R_GRN;
                served_a_n = 1'b0;
                served_b_n = 1'b0;
            end
        endcase
    end

    always_comb begin
        light_a = L_RED;
        light_b = L_RED;
        unique case (state)
            A_GRN:   light_a = L_GRN;
            A_YEL:   light_a = L_YEL;
            B_GRN:   light_b = L_GRN;
            B_YEL:   light_b = L_YEL;
            default: begin
                light_a = L_RED;
                light_b = L_RED;
            end
        endcase
    end

    assign walk_a = (state == A_GRN) && served_a;
    assign walk_b = (state == B_GRN) && served_b;
    assign phase  = state;

endmodule
